// File: rtl/fir_interp_sched.sv
// Sample scheduler and coefficient-write arbiter for the polyphase FIR interpolator.
// Issues one FIFO sample (or a zero on underrun) every per_q clocks, never faster than one filter frame.
module fir_interp_sched #(
    parameter int DATA_WIDTH    = 16,
    parameter int COEF_WIDTH    = 16,
    parameter int FILTER_ORDER  = 256,
    parameter int INTERPOLATION = 32,
    parameter int COEF_AWIDTH   = $clog2(FILTER_ORDER),
    parameter int FIFO_DEPTH    = 8,
    parameter int PERIOD_WIDTH  = 16,
    parameter int MIN_PERIOD    = INTERPOLATION * (FILTER_ORDER / INTERPOLATION + 2) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [PERIOD_WIDTH-1:0]       period_i,
    input  logic [DATA_WIDTH-1:0]         s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic                          cfg_we_i,
    input  logic [COEF_AWIDTH-1:0]        cfg_addr_i,
    input  logic [COEF_WIDTH-1:0]         cfg_data_i,
    output logic                          cfg_ready_o,
    output logic [DATA_WIDTH-1:0]         fir_data_o,
    output logic                          fir_data_val_o,
    output logic                          fir_coef_we_o,
    output logic [COEF_AWIDTH-1:0]        fir_coef_addr_o,
    output logic [COEF_WIDTH-1:0]         fir_coef_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          underrun_o,
    output logic                          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [PERIOD_WIDTH-1:0] MIN_PER = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE     = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] TWO     = PERIOD_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] p);
        return (p < MIN_PER) ? MIN_PER : p;
    endfunction

    state_t                  state, state_nxt;
    logic [PERIOD_WIDTH-1:0] cnt, cnt_nxt, per_q, per_nxt;
    logic                    tick, push, pop, full, empty, accept;
    logic [LW-1:0]           wptr, rptr, level;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

    assign level        = wptr - rptr;
    assign full         = (level == LW'(FIFO_DEPTH));
    assign empty        = (level == '0);
    assign s_ready_o    = !full && !rst_i;
    assign push         = s_valid_i && s_ready_o;
    assign tick         = (state == RUN) && (cnt == '0);
    // Pop decision uses pre-push occupancy, so a sample arriving on a tick cycle waits.
    assign pop          = tick && !empty;
    assign fifo_level_o = level;
    assign busy_o       = (state != IDLE);

    // Writes only land where the whole remaining frame fits before the next issue.
    assign cfg_ready_o  = !rst_i && ((state == IDLE) ||
                          ((state == RUN) && (cnt >= TWO) && (cnt <= per_q - MIN_PER)));
    assign accept       = cfg_we_i && cfg_ready_o;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        per_nxt   = per_q;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable_i) state_nxt = RUN;
            end
            RUN: begin
                if (tick) begin
                    per_nxt = clamp_period(period_i);
                    cnt_nxt = per_nxt - ONE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
                if (!enable_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt != '0) cnt_nxt = cnt - ONE;
                if (enable_i)          state_nxt = RUN;
                else if (cnt == '0)    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            per_q <= MIN_PER;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            per_q <= per_nxt;
            if (push) wptr <= wptr + LW'(1);
            if (pop)  rptr <= rptr + LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[AW-1:0]] <= s_data_i;
    end

    // Output stage: everything toward the filter is registered one clock after its decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fir_data_o      <= '0;
            fir_data_val_o  <= 1'b0;
            underrun_o      <= 1'b0;
            fir_coef_we_o   <= 1'b0;
            fir_coef_addr_o <= '0;
            fir_coef_data_o <= '0;
        end else begin
            fir_data_o      <= pop ? mem[rptr[AW-1:0]] : '0;
            fir_data_val_o  <= tick;
            underrun_o      <= tick && empty;
            fir_coef_we_o   <= accept;
            fir_coef_addr_o <= accept ? cfg_addr_i : '0;
            fir_coef_data_o <= accept ? cfg_data_i : '0;
        end
    end

endmodule

// File: tb/tb_fir_interp_sched.sv
// Bench for fir_interp_sched: directed scenarios with hand-derived timing plus a randomized run,
// all checked every cycle against a queue-based schedule model.
module tb_fir_interp_sched;

    localparam int MINP = 321;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ready;
    logic [15:0] fir_data;
    logic        fir_data_val;
    logic        fir_coef_we;
    logic [7:0]  fir_coef_addr;
    logic [15:0] fir_coef_data;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        busy;

    fir_interp_sched dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .period_i(period),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
        .fir_data_o(fir_data), .fir_data_val_o(fir_data_val), .fir_coef_we_o(fir_coef_we),
        .fir_coef_addr_o(fir_coef_addr), .fir_coef_data_o(fir_coef_data),
        .fifo_level_o(fifo_level), .underrun_o(underrun), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: sample queue, schedule mode and clocks remaining until the next issue.
    int q[$];
    bit m_on = 0, m_drain = 0;
    int m_left = 0, m_per = MINP;
    bit e_val = 0, e_und = 0, e_cwe = 0, e_zero = 1;
    int e_data = 0, e_caddr = 0, e_cdata = 0;

    int val_cyc[$], val_dat[$], und_cyc[$], cwe_cyc[$];

    always @(negedge clk) begin
        bit tk, crdy, srdy;
        int lvl, old;
        lvl  = q.size();
        srdy = !rst && (lvl < 8);
        tk   = m_on && !m_drain && (m_left == 0);
        crdy = !rst && (!m_on || (!m_drain && m_left >= 2 && m_left <= m_per - MINP));

        chk("s_ready", 32'(s_ready), 32'(srdy));
        chk("cfg_ready", 32'(cfg_ready), 32'(crdy));
        chk("fifo_level", 32'(fifo_level), 32'(lvl));
        chk("busy", 32'(busy), 32'(m_on));
        chk("fir_data_val", 32'(fir_data_val), 32'(e_val));
        chk("underrun", 32'(underrun), 32'(e_und));
        chk("fir_coef_we", 32'(fir_coef_we), 32'(e_cwe));
        if (e_val || e_zero) chk("fir_data", 32'(fir_data), 32'(e_data));
        if (e_cwe || e_zero) begin
            chk("fir_coef_addr", 32'(fir_coef_addr), 32'(e_caddr));
            chk("fir_coef_data", 32'(fir_coef_data), 32'(e_cdata));
        end

        if (fir_data_val) begin
            val_cyc.push_back(cyc);
            val_dat.push_back(int'(fir_data));
        end
        if (underrun)    und_cyc.push_back(cyc);
        if (fir_coef_we) cwe_cyc.push_back(cyc);

        if (rst) begin
            q.delete();
            m_on = 0; m_drain = 0; m_left = 0; m_per = MINP;
            e_val = 0; e_und = 0; e_cwe = 0; e_data = 0; e_caddr = 0; e_cdata = 0; e_zero = 1;
        end else begin
            e_zero  = 0;
            e_cwe   = cfg_we && crdy;
            e_caddr = e_cwe ? int'(cfg_addr) : 0;
            e_cdata = e_cwe ? int'(cfg_data) : 0;
            e_val   = tk;
            e_und   = tk && (lvl == 0);
            e_data  = 0;
            if (tk && lvl > 0) e_data = q.pop_front();
            if (s_valid && srdy) q.push_back(int'(s_data));
            if (!m_on) begin
                m_left = 0;
                if (enable) begin m_on = 1; m_drain = 0; end
            end else if (!m_drain) begin
                if (tk) begin
                    m_per  = (int'(period) < MINP) ? MINP : int'(period);
                    m_left = m_per - 1;
                end else begin
                    m_left = m_left - 1;
                end
                if (!enable) m_drain = 1;
            end else begin
                old = m_left;
                if (old > 0) m_left = old - 1;
                if (enable)        m_drain = 0;
                else if (old == 0) m_on = 0;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d);
        s_valid = 1'b1;
        s_data  = 16'(d);
        next();
        s_valid = 1'b0;
    endtask

    task automatic clear_logs();
        val_cyc.delete(); val_dat.delete(); und_cyc.delete(); cwe_cyc.delete();
    endtask

    task automatic wait_vals(input int n, input int budget, input string nm);
        int k = 0;
        while (val_cyc.size() < n && k < budget) begin
            next();
            k++;
        end
        chk(nm, 32'(val_cyc.size()), 32'(n));
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        enable = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 1500);
        chk(nm, 32'(busy), 32'd0);
        next();
    endtask

    initial begin
        int e, n, first, last, vp;

        // Reset
        repeat (3) next();
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_fir_data_val", 32'(fir_data_val), 32'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        next();

        // Minimum spacing with three preloaded samples
        period = 16'd0;
        push(16'h1111); push(16'h2222); push(16'h3333);
        clear_logs();
        enable = 1'b1;
        e = cyc;
        wait_vals(3, 1000, "t1_count");
        if (val_cyc.size() >= 3) begin
            chk("t1_first_latency", 32'(val_cyc[0] - e), 32'd2);
            chk("t1_spacing_a", 32'(val_cyc[1] - val_cyc[0]), 32'd321);
            chk("t1_spacing_b", 32'(val_cyc[2] - val_cyc[1]), 32'd321);
            chk("t1_data0", 32'(val_dat[0]), 32'h1111);
            chk("t1_data1", 32'(val_dat[1]), 32'h2222);
            chk("t1_data2", 32'(val_dat[2]), 32'h3333);
        end
        wait_idle("t1_idle");

        // Underrun after the only sample
        period = 16'd1000;
        push(16'h0ABC);
        clear_logs();
        enable = 1'b1;
        wait_vals(2, 2200, "t2_count");
        if (val_cyc.size() >= 2) begin
            chk("t2_data0", 32'(val_dat[0]), 32'h0ABC);
            chk("t2_data1_zero", 32'(val_dat[1]), 32'd0);
            chk("t2_spacing", 32'(val_cyc[1] - val_cyc[0]), 32'd1000);
            chk("t2_underrun_count", 32'(und_cyc.size()), 32'd1);
            if (und_cyc.size() >= 1) chk("t2_underrun_cycle", 32'(und_cyc[0]), 32'(val_cyc[1]));
        end
        wait_idle("t2_idle");

        // Held coefficient write during RUN, period 1000
        period   = 16'd1000;
        cfg_addr = 8'd7;
        cfg_data = 16'h0055;
        cfg_we   = 1'b1;
        clear_logs();
        enable = 1'b1;
        wait_vals(3, 2200, "t4_count");
        if (val_cyc.size() >= 3) begin
            n = 0; first = -1; last = -1;
            foreach (cwe_cyc[i]) begin
                if (cwe_cyc[i] > val_cyc[1] && cwe_cyc[i] < val_cyc[2]) begin
                    n++;
                    if (first < 0) first = cwe_cyc[i];
                    last = cwe_cyc[i];
                end
            end
            chk("t4_accept_count", 32'(n), 32'd678);
            chk("t4_first_accept", 32'(first - val_cyc[1]), 32'd321);
            chk("t4_last_accept", 32'(val_cyc[2] - last), 32'd2);
        end
        cfg_we = 1'b0;
        wait_idle("t4_idle");

        // Enable dropped mid-frame; write waits out DRAIN
        period = 16'd1000;
        clear_logs();
        enable = 1'b1;
        wait_vals(1, 10, "t5_first");
        repeat (10) next();
        enable   = 1'b0;
        cfg_addr = 8'd5;
        cfg_data = 16'h1234;
        cfg_we   = 1'b1;
        cwe_cyc.delete();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 1200);
        chk("t5_reached_idle", 32'(busy), 32'd0);
        chk("t5_no_write_in_drain", 32'(cwe_cyc.size()), 32'd0);
        chk("t5_cfg_ready_idle", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        chk("t5_coef_we", 32'(fir_coef_we), 32'd1);
        chk("t5_coef_addr", 32'(fir_coef_addr), 32'd5);
        chk("t5_coef_data", 32'(fir_coef_data), 32'h1234);
        next();
        cfg_we = 1'b0;
        next();

        // FIFO full, ninth push held, then one pop
        for (int i = 0; i < 8; i++) push(16'h0100 + i);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        @(negedge clk);
        chk("t3_level_full", 32'(fifo_level), 32'd8);
        chk("t3_s_ready_full", 32'(s_ready), 32'd0);
        next(); next();
        @(negedge clk);
        chk("t3_level_held", 32'(fifo_level), 32'd8);
        next();
        s_valid = 1'b0;
        period  = 16'd0;
        clear_logs();
        enable = 1'b1;
        e = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fifo_level != 4'd7 && n < 10);
        chk("t3_level_after_pop", 32'(fifo_level), 32'd7);
        chk("t3_s_ready_after_pop", 32'(s_ready), 32'd1);
        chk("t3_pop_latency", 32'(cyc - e), 32'd2);
        next();
        if (val_dat.size() >= 1) chk("t3_pop_head", 32'(val_dat[0]), 32'h0100);

        // Reset in the middle of RUN with four samples queued
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fifo_level != 4'd4 && n < 1500);
        chk("t6_level_before", 32'(fifo_level), 32'd4);
        next();
        repeat (50) next();
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("t6_s_ready_in_rst", 32'(s_ready), 32'd0);
        chk("t6_cfg_ready_in_rst", 32'(cfg_ready), 32'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_val", 32'(fir_data_val), 32'd0);
        chk("t6_underrun", 32'(underrun), 32'd0);
        chk("t6_fir_data", 32'(fir_data), 32'd0);
        next();
        clear_logs();
        repeat (700) next();
        chk("t6_no_more_val", 32'(val_cyc.size()), 32'd0);

        // Randomized run, model-checked every cycle
        enable = 1'b1;
        vp = 1;
        for (int i = 0; i < 15000; i++) begin
            if (i % 1000 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vp = 1;
                    1:       vp = 3;
                    default: vp = 200;
                endcase
            end
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 999) == 0) begin
                case ($urandom_range(0, 4))
                    0:       period = 16'd0;
                    1:       period = 16'd320;
                    2:       period = 16'd321;
                    3:       period = 16'd322;
                    default: period = 16'($urandom_range(322, 1200));
                endcase
            end
            s_valid  = ($urandom_range(0, 399) < vp);
            s_data   = 16'($urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = 8'($urandom);
            cfg_data = 16'($urandom);
            rst      = ($urandom_range(0, 4999) == 0);
            next();
        end
        rst = 1'b0; s_valid = 1'b0; cfg_we = 1'b0; enable = 1'b0;
        repeat (3) next();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
